// File: rtl/banco_registros_if.sv
// Register-file access bundle: ID read ports, WB write port and debug read port.
// The master drives indices and write requests; the slave returns read data and the write-done pulse.
interface banco_registros_if #(
  parameter int NBITS_DATA = 32,
  parameter int NBITS_REG  = 5
);
  logic                  i_enable;
  logic                  i_RegWrite;
  logic [NBITS_REG-1:0]  i_reg_write;
  logic [NBITS_DATA-1:0] i_write_data;
  logic [NBITS_REG-1:0]  i_reg_rs;
  logic [NBITS_REG-1:0]  i_reg_rt;
  logic [NBITS_REG-1:0]  i_debug_addr;
  logic [NBITS_DATA-1:0] o_data_rs;
  logic [NBITS_DATA-1:0] o_data_rt;
  logic [NBITS_DATA-1:0] o_debug_data;
  logic                  o_write_done;

  modport master (
    output i_enable, i_RegWrite, i_reg_write, i_write_data,
    output i_reg_rs, i_reg_rt, i_debug_addr,
    input  o_data_rs, o_data_rt, o_debug_data, o_write_done
  );

  modport slave (
    input  i_enable, i_RegWrite, i_reg_write, i_write_data,
    input  i_reg_rs, i_reg_rt, i_debug_addr,
    output o_data_rs, o_data_rt, o_debug_data, o_write_done
  );
endinterface

// File: rtl/banco_registros.sv
// MIPS 32x32 register file: three zero-latency read ports with write-through bypass,
// one write port committed on the rising edge; no backpressure, i_enable=0 freezes storage.
module banco_registros #(
  parameter int NBITS_DATA = 32,
  parameter int NBITS_REG  = 5,
  parameter int NREGS      = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  banco_registros_if.slave     bus
);

  logic [NBITS_DATA-1:0] r_regs [NREGS];
  logic                  r_write_done;
  logic                  w_commit;

  // Same qualifier drives both the edge commit and the same-cycle bypass.
  assign w_commit = !i_reset && bus.i_enable && bus.i_RegWrite &&
                    (bus.i_reg_write != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
      r_write_done <= 1'b0;
    end else begin
      r_write_done <= w_commit;
      if (w_commit) begin
        r_regs[bus.i_reg_write] <= bus.i_write_data;
      end
    end
  end

  function automatic logic [NBITS_DATA-1:0] f_read(input logic [NBITS_REG-1:0] idx);
    if (idx == '0) begin
      return '0;
    end else if (w_commit && (idx == bus.i_reg_write)) begin
      return bus.i_write_data;
    end else begin
      return r_regs[idx];
    end
  endfunction

  assign bus.o_data_rs    = f_read(bus.i_reg_rs);
  assign bus.o_data_rt    = f_read(bus.i_reg_rt);
  assign bus.o_debug_data = f_read(bus.i_debug_addr);
  assign bus.o_write_done = r_write_done;

endmodule
